// File: rtl/mem_dp_clr.sv
// True dual-port synchronous RAM with per-port enables, read-valid flags,
// 1- or 2-cycle read latency, write-first/read-first return and a clear sweep.
module mem_dp_clr #(
    parameter int              AMSB    = 9,
    parameter int              DMSB    = 11,
    parameter string           FILE    = "ram.mem",
    parameter int              LAT     = 1,
    parameter int              RDMODE  = 0,
    parameter int              CLR_RST = 0,
    parameter logic [DMSB:0]   CLR_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    output logic            busy,
    output logic            done,
    input  logic            ena,
    input  logic            wra,
    input  logic [AMSB:0]   ada,
    input  logic [DMSB:0]   dina,
    output logic [DMSB:0]   douta,
    output logic            vala,
    input  logic            enb,
    input  logic            wrb,
    input  logic [AMSB:0]   adb,
    input  logic [DMSB:0]   dinb,
    output logic [DMSB:0]   doutb,
    output logic            valb
);

    localparam int DEPTH = 2 ** (AMSB + 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          r_state;
    logic [AMSB:0]   r_cnt;
    logic            r_pend;
    logic            r_busy;
    logic            r_done;
    logic [DMSB:0]   r_mem [DEPTH];
    logic [DMSB:0]   r_d1a, r_d1b;
    logic            r_v1a, r_v1b;

    logic            w_acc_a, w_acc_b;
    logic            w_we_a, w_we_b;
    logic [DMSB:0]   w_rd_a, w_rd_b;

    if (LAT != 1 && LAT != 2) begin : g_bad_lat
        $error("mem_dp_clr: LAT must be 1 or 2");
    end

    // Ports are locked out entirely while the sweep owns the array.
    assign w_acc_a = (r_state == S_IDLE) && ena;
    assign w_acc_b = (r_state == S_IDLE) && enb;
    assign w_we_a  = w_acc_a && wra;
    assign w_we_b  = w_acc_b && wrb;
    assign w_rd_a  = (w_we_a && RDMODE == 0) ? dina : r_mem[ada];
    assign w_rd_b  = (w_we_b && RDMODE == 0) ? dinb : r_mem[adb];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pend  <= (CLR_RST != 0);
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr || r_pend) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_pend  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the array is never reset; reset only blocks writes on its own edge.
    // Port B is written first so port A wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cnt] <= CLR_VAL;
            end else begin
                if (w_we_b) r_mem[adb] <= dinb;
                if (w_we_a) r_mem[ada] <= dina;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d1a <= '0;
            r_d1b <= '0;
            r_v1a <= 1'b0;
            r_v1b <= 1'b0;
        end else begin
            r_v1a <= w_acc_a;
            r_v1b <= w_acc_b;
            if (w_acc_a) r_d1a <= w_rd_a;
            if (w_acc_b) r_d1b <= w_rd_b;
        end
    end

    if (LAT == 2) begin : g_lat2
        logic [DMSB:0] r_d2a, r_d2b;
        logic          r_v2a, r_v2b;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_d2a <= '0;
                r_d2b <= '0;
                r_v2a <= 1'b0;
                r_v2b <= 1'b0;
            end else begin
                r_d2a <= r_d1a;
                r_d2b <= r_d1b;
                r_v2a <= r_v1a;
                r_v2b <= r_v1b;
            end
        end

        assign douta = r_d2a;
        assign doutb = r_d2b;
        assign vala  = r_v2a;
        assign valb  = r_v2b;
    end else begin : g_lat1
        assign douta = r_d1a;
        assign doutb = r_d1b;
        assign vala  = r_v1a;
        assign valb  = r_v1b;
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mem_dp_clr.sv
// Bench for mem_dp_clr: two instances (LAT=1 write-first, LAT=2 read-first) share
// stimulus; a word-array model feeds per-port queues that a negedge monitor drains.
module tb_mem_dp_clr;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [11:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, clr;
    logic        ena, wra, enb, wrb;
    logic [9:0]  ada, adb;
    logic [11:0] dina, dinb;
    logic        busy [2];
    logic        done [2];
    logic        vala [2];
    logic        valb [2];
    logic [11:0] douta [2];
    logic [11:0] doutb [2];

    exp_t        q [4][$];
    logic [11:0] last_out [4];
    logic [11:0] mdl [2][DEPTH];
    int          cyc = 0;
    logic        rst_q = 1'b0;
    int          busy_cnt [2];
    int          done_cnt [2];
    logic        prev_busy [2];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    mem_dp_clr #(.AMSB(9), .DMSB(11), .FILE(""), .LAT(1), .RDMODE(0),
                 .CLR_RST(0), .CLR_VAL(12'hFFF)) u_dut0 (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy[0]), .done(done[0]),
        .ena(ena), .wra(wra), .ada(ada), .dina(dina), .douta(douta[0]), .vala(vala[0]),
        .enb(enb), .wrb(wrb), .adb(adb), .dinb(dinb), .doutb(doutb[0]), .valb(valb[0])
    );

    mem_dp_clr #(.AMSB(9), .DMSB(11), .FILE(""), .LAT(2), .RDMODE(1),
                 .CLR_RST(0), .CLR_VAL(12'h5A5)) u_dut1 (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy[1]), .done(done[1]),
        .ena(ena), .wra(wra), .ada(ada), .dina(dina), .douta(douta[1]), .vala(vala[1]),
        .enb(enb), .wrb(wrb), .adb(adb), .dinb(dinb), .doutb(doutb[1]), .valb(valb[1])
    );

    function automatic logic [11:0] clrv(input int d);
        return (d == 0) ? 12'hFFF : 12'h5A5;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit read_first(input int d);
        return d != 0;
    endfunction

    task automatic check(input string name, input int p, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (dut%0d port%0d) cyc %0d: got 0x%0h expected 0x%0h",
                      name, p / 2, p % 2, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0;
        ena = 1'b0; wra = 1'b0; ada = '0; dina = '0;
        enb = 1'b0; wrb = 1'b0; adb = '0; dinb = '0;
    endtask

    // Traffic presented while a sweep runs; it must leave no trace.
    task automatic junk();
        clr  = ($urandom_range(0, 7) == 0);
        ena  = $urandom_range(0, 1) != 0;
        wra  = $urandom_range(0, 1) != 0;
        ada  = 10'($urandom);
        dina = 12'($urandom);
        enb  = $urandom_range(0, 1) != 0;
        wrb  = $urandom_range(0, 1) != 0;
        adb  = 10'($urandom);
        dinb = 12'($urandom);
    endtask

    task automatic issue(input logic ea, input logic wa, input logic [9:0] aa,
                         input logic [11:0] da, input logic eb, input logic wb,
                         input logic [9:0] ab, input logic [11:0] db);
        exp_t e;
        logic [11:0] old_a, old_b;
        ena = ea; wra = wa; ada = aa; dina = da;
        enb = eb; wrb = wb; adb = ab; dinb = db;
        clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            old_a = mdl[d][aa];
            old_b = mdl[d][ab];
            if (ea) begin
                e.data = (wa && !read_first(d)) ? da : old_a;
                e.cyc  = cyc + lat_of(d);
                q[2 * d].push_back(e);
            end
            if (eb) begin
                e.data = (wb && !read_first(d)) ? db : old_b;
                e.cyc  = cyc + lat_of(d);
                q[2 * d + 1].push_back(e);
            end
            if (eb && wb) mdl[d][ab] = db;
            if (ea && wa) mdl[d][aa] = da;
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic [11:0] d);
        exp_t e;
        if (rst_q) begin
            check("reset_valid", p, 32'(v), 32'd0);
            check("reset_dout", p, 32'(d), 32'd0);
            last_out[p] = '0;
            q[p].delete();
        end else if (v) begin
            if (q[p].size() == 0) begin
                check("unexpected_valid", p, 32'(v), 32'd0);
            end else begin
                e = q[p].pop_front();
                check("read_data", p, 32'(d), 32'(e.data));
                check("read_latency", p, cyc, e.cyc);
                last_out[p] = e.data;
            end
        end else begin
            if (q[p].size() != 0 && q[p][0].cyc <= cyc) begin
                check("missing_valid", p, 32'(v), 32'd1);
                void'(q[p].pop_front());
            end
            check("dout_hold", p, 32'(d), 32'(last_out[p]));
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                mon_port(2 * d, vala[d], douta[d]);
                mon_port(2 * d + 1, valb[d], doutb[d]);
                if (rst_q) begin
                    check("reset_busy", 2 * d, 32'(busy[d]), 32'd0);
                    check("reset_done", 2 * d, 32'(done[d]), 32'd0);
                end
                if (busy[d]) busy_cnt[d]++;
                if (done[d]) begin
                    done_cnt[d]++;
                    check("done_edge", 2 * d, 32'({prev_busy[d], busy[d]}), 32'b10);
                end
                prev_busy[d] = busy[d];
            end
        end
    endtask

    initial begin
        int          b0 [2];
        int          d0 [2];
        logic [9:0]  ra, rb;

        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last_out[i] = '0;
        end
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; done_cnt[d] = 0; prev_busy[d] = 1'b0;
        end
        fork
            monitor();
        join_none

        repeat (4) tick();
        reset = 1'b0;
        tick();

        // Full sweep with hostile traffic and repeated clr requests while busy.
        for (int d = 0; d < 2; d++) begin b0[d] = busy_cnt[d]; d0[d] = done_cnt[d]; end
        idle_inputs();
        clr = 1'b1;
        tick();
        repeat (DEPTH) begin junk(); tick(); end
        idle_inputs();
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            check("sweep_busy_cycles", 2 * d, busy_cnt[d] - b0[d], DEPTH);
            check("sweep_done_pulses", 2 * d, done_cnt[d] - d0[d], 1);
            for (int w = 0; w < DEPTH; w++) mdl[d][w] = clrv(d);
        end

        // Every word must now hold the clear value.
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 1'b0, 10'(i), 12'h0, 1'b1, 1'b0, 10'(DEPTH - 1 - i), 12'h0);
            tick();
        end

        // Directed cases, including same-address cross-port collisions.
        issue(1'b1, 1'b1, 10'h005, 12'h123, 1'b0, 1'b0, 10'h000, 12'h000); tick();
        issue(1'b1, 1'b0, 10'h005, 12'h000, 1'b0, 1'b0, 10'h000, 12'h000); tick();
        issue(1'b0, 1'b1, 10'h005, 12'hEEE, 1'b0, 1'b1, 10'h005, 12'hDDD); tick();
        issue(1'b0, 1'b0, 10'h000, 12'h000, 1'b1, 1'b0, 10'h005, 12'h000); tick();
        issue(1'b1, 1'b1, 10'h010, 12'hABC, 1'b1, 1'b1, 10'h010, 12'h456); tick();
        issue(1'b0, 1'b0, 10'h000, 12'h000, 1'b1, 1'b0, 10'h010, 12'h000); tick();
        issue(1'b1, 1'b1, 10'h020, 12'h111, 1'b0, 1'b0, 10'h000, 12'h000); tick();
        issue(1'b1, 1'b1, 10'h020, 12'h777, 1'b1, 1'b0, 10'h020, 12'h000); tick();
        issue(1'b0, 1'b0, 10'h000, 12'h000, 1'b1, 1'b0, 10'h020, 12'h000); tick();
        issue(1'b1, 1'b1, 10'h3FF, 12'h00F, 1'b0, 1'b0, 10'h000, 12'h000); tick();
        issue(1'b1, 1'b1, 10'h3FF, 12'h0F0, 1'b0, 1'b0, 10'h000, 12'h000); tick();
        idle_inputs(); tick(); tick();
        issue(1'b1, 1'b0, 10'h3FF, 12'h000, 1'b1, 1'b0, 10'h000, 12'h000); tick();
        idle_inputs(); repeat (3) tick();

        // Random traffic concentrated on a few words to force collisions.
        for (int i = 0; i < 2000; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ra = 10'h3FF;
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, ra, 12'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, rb, 12'($urandom));
            tick();
        end
        idle_inputs(); repeat (3) tick();

        // Seed the words around 0x100, then abort a sweep just as it reaches 0x100.
        for (int i = 10'h0F0; i < 10'h110; i++) begin
            issue(1'b1, 1'b1, 10'(i), 12'($urandom), 1'b0, 1'b0, 10'h000, 12'h000);
            tick();
        end
        idle_inputs(); repeat (3) tick();
        for (int d = 0; d < 2; d++) begin b0[d] = busy_cnt[d]; d0[d] = done_cnt[d]; end
        clr = 1'b1;
        tick();
        repeat (256) begin junk(); tick(); end
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            check("abort_busy_cycles", 2 * d, busy_cnt[d] - b0[d], 257);
            check("abort_done_pulses", 2 * d, done_cnt[d] - d0[d], 0);
            for (int w = 0; w < 256; w++) mdl[d][w] = clrv(d);
        end
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, 1'b0, 10'(10'h0F0 + i), 12'h000, 1'b1, 1'b0, 10'($urandom), 12'h000);
            tick();
        end

        idle_inputs();
        repeat (6) tick();
        for (int p = 0; p < 4; p++) check("drain", p, q[p].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
